fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single Sync FIFO write port (wr_en / write_data) between NREQ requesters. Requester 0 is the APB slave path; the others are stream sources.
- Each requester has a 1-deep holding register with valid/ready handshake.
- Round-robin arbitration with a bounded burst length.
- Write issue is throttled from the FIFO's combinational fifo_status so the FIFO is never overflowed.

Parameters:
- WIDTH, 32, data width of each requester and of the FIFO write port
- NREQ, 2, number of requesters (2..8)
- IDW, 3, width of grant_id (must satisfy 2^IDW >= NREQ)
- BURST_MAX, 4, maximum consecutive writes granted to one requester while another is pending (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arb_en  in  1  1 = arbitration enabled; 0 = no new grants (holding registers still accept data)
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  per-requester holding register empty
- fifo_status  in  3  FIFO level: 0 empty, 1 3/4 empty, 2 2/4 empty, 3 1/4 empty, 4 0/4 empty, 5 full
- fifo_wr_en  out  1  registered write strobe to FIFO
- fifo_wdata  out  WIDTH  registered write data to FIFO
- grant_id  out  IDW  index of the requester written by the current fifo_wr_en
- stall  out  1  registered; 1 while pending data is blocked by the FIFO level

Behaviour:
- Reset (async, rst_n=0): state IDLE; all holding registers empty; rr_ptr=0; burst_cnt=0; fifo_wr_en=0; fifo_wdata=0; grant_id=0; stall=0; req_ready all 1 one cycle after release.
- Reset mid-operation discards held data; no write strobe is emitted.
- Holding: req_ready[i] = !hold_vld[i] (combinational from the register). Capture occurs on req_valid[i] && req_ready[i].
- Capture is registered, so data accepted at edge t is eligible for grant at edge t+1. hold_vld[i] is cleared on the edge its write issues.
- A requester is never re-ready in the same cycle it is drained; sustained throughput per requester is 1 word per 2 cycles.
- Write permission (ok) per cycle:
  - fifo_status==5 -> ok=0.
  - fifo_status==4 -> ok = !fifo_wr_en. Alternate cycles, so the status reflects the previous write.
  - otherwise ok=1.
- Selection: first i with hold_vld[i], scanning from rr_ptr upward modulo NREQ.
- Grant issue, on the edge where ok && arb_en && any hold_vld:
  - fifo_wr_en=1, fifo_wdata=hold_data[sel], grant_id=sel.
  - Otherwise fifo_wr_en=0; fifo_wdata and grant_id hold their last values.
- FSM:
  - IDLE: no pending data. Go to BURST when any hold_vld && arb_en && ok. Go to STALL when any hold_vld && arb_en && !ok.
  - BURST: the current owner keeps priority while hold_vld[owner] && burst_cnt<BURST_MAX.
    - burst_cnt increments per write to the owner.
    - At BURST_MAX, or when the owner goes empty: rr_ptr=owner+1 mod NREQ and burst_cnt=0, then reselect.
    - If no other requester is pending, the owner continues and burst_cnt restarts at 1.
    - Go to STALL on !ok with pending data. Go to IDLE when nothing is pending.
  - STALL: stall=1. Go to BURST when ok returns; the owner and burst_cnt are preserved. Go to IDLE if arb_en=0.
- stall=1 only in STALL. A throttle gap at status 4 is not a stall.
- arb_en deasserted mid-burst: the write already issued completes; no further grants; FSM goes to IDLE; burst_cnt=0.
- Simultaneous capture and drain on different requesters are independent.

Decomposition:
- Shared package fifo_pkg holds:
  - the FIFO status encodings (ST_EMPTY..ST_FULL = 0..5);
  - the FSM state constants IDLE/BURST/STALL, one-hot, 3 bits.
- Sub-module rr_pick (combinational round-robin priority finder: hold_vld, rr_ptr -> sel, any), instantiated once.

Test Plan:
- Single write: reset, fifo_status=0, req0 presents 32'hDEAD_BEEF for 1 cycle -> req_ready[0]=0 next cycle; fifo_wr_en=1 with fifo_wdata=DEAD_BEEF and grant_id=0 one cycle after capture; req_ready[0]=1 the cycle after.
- Round-robin and burst: BURST_MAX=4, both requesters continuously valid with incrementing data, status=0 -> grant_id sequence 0,0,0,0,1,1,1,1,0...
  - Per-requester 1-in-2 acceptance limits the actual pattern; the check is that no requester gets more than 4 consecutive grants while the other is pending.
- Full: status=5 with req1 holding 32'h1 -> no fifo_wr_en; stall=1 after 1 cycle; req_ready[1]=0. Status drops to 4 -> exactly one write of 32'h1; stall=0.
- Near-full throttle: status held at 4, both requesters saturated for 10 cycles -> fifo_wr_en never high on two consecutive cycles; 5 writes total.
- Reset mid-burst: rst_n low during BURST with both holds full -> fifo_wr_en=0 and req_ready=0 while reset is asserted; req_ready=2'b11 the cycle after release; no stale data written.
- arb_en=0 with req0 data 32'hA5A5_A5A5 held -> no write, stall=0. Set arb_en=1 -> written within 1 cycle with grant_id=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared encodings for the FIFO write-port arbiter: FIFO level codes, FSM states
// and the per-cycle write-permission rule derived from the FIFO level.
package fifo_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_3Q    = 3'd1,
    ST_2Q    = 3'd2,
    ST_1Q    = 3'd3,
    ST_0Q    = 3'd4,
    ST_FULL  = 3'd5
  } fifo_status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BURST = 3'b010,
    STALL = 3'b100
  } arb_state_e;

  // At the last free slot only every other cycle may write, so the FIFO level
  // has caught up with the previous write before the next one is issued.
  function automatic logic wr_permit(input logic [2:0] status, input logic wr_q);
    if (status == ST_FULL) return 1'b0;
    if (status == ST_0Q)   return !wr_q;
    return 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port signals of the arbiter; the arbiter uses the
// slave view, the requester/FIFO side uses the master view.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
);
  logic                    arb_en;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic [2:0]              fifo_status;
  logic                    fifo_wr_en;
  logic [WIDTH-1:0]        fifo_wdata;
  logic [IDW-1:0]          grant_id;
  logic                    stall;

  modport master (
    output arb_en, req_valid, req_data, fifo_status,
    input  req_ready, fifo_wr_en, fifo_wdata, grant_id, stall
  );

  modport slave (
    input  arb_en, req_valid, req_data, fifo_status,
    output req_ready, fifo_wr_en, fifo_wdata, grant_id, stall
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of vld at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] vld,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  sel,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;
  logic            found;

  always_comb begin
    rot   = NREQ'({vld, vld} >> ptr);
    sel   = '0;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        sel   = sum[IDW-1:0];
      end
    end
  end

  assign any = |vld;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NREQ requesters, each behind a 1-deep holding
// register, with round-robin bursts capped at BURST_MAX and level-based throttling.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 2,
  parameter int IDW       = 3,
  parameter int BURST_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] hold_data_q [NREQ];
  logic [WIDTH-1:0] hold_data_d [NREQ];
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic             fifo_wr_en_q, fifo_wr_en_d;
  logic [WIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             stall_q, stall_d;
  logic             rdy_en_q;

  logic [NREQ-1:0]  req_ready, capture, drain;
  logic             ok, full_blk, active, owner_vld, keep, issue, any_vld;
  logic [IDW-1:0]   pick_ptr, sel;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] p);
    return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready stays low through reset and rises on the first clock after release.
  assign req_ready = {NREQ{rdy_en_q}} & ~hold_vld_q;
  assign capture   = bus.req_valid & req_ready;
  assign ok        = wr_permit(bus.fifo_status, fifo_wr_en_q);
  assign full_blk  = (bus.fifo_status == ST_FULL);
  assign active    = (state_q != IDLE);

  always_comb begin
    owner_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) owner_vld = hold_vld_q[i];
    end
  end

  // Owner keeps priority inside its burst window; otherwise scan from the slot after it.
  assign keep     = active && owner_vld && (burst_cnt_q < 4'(BURST_MAX));
  assign pick_ptr = keep ? owner_q : (active ? next_idx(owner_q) : rr_ptr_q);

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .vld (hold_vld_q),
    .ptr (pick_ptr),
    .sel (sel),
    .any (any_vld)
  );

  assign issue = ok && bus.arb_en && any_vld;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) sel_data = hold_data_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      hold_data_d[i] = capture[i] ? bus.req_data[i*WIDTH +: WIDTH] : hold_data_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    fifo_wr_en_d = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    grant_id_d   = grant_id_q;
    drain        = '0;

    for (int i = 0; i < NREQ; i++) begin
      drain[i] = issue && (sel == IDW'(i));
    end

    if (issue) begin
      fifo_wr_en_d = 1'b1;
      fifo_wdata_d = sel_data;
      grant_id_d   = sel;
      state_d      = BURST;
      if (keep) begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end else begin
        if (active) rr_ptr_d = next_idx(owner_q);
        owner_d     = sel;
        burst_cnt_d = 4'd1;
      end
    end else if (!bus.arb_en) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end else if (!any_vld) begin
      if (active) rr_ptr_d = next_idx(owner_q);
      state_d     = IDLE;
      burst_cnt_d = '0;
    end else if (full_blk) begin
      // Entering from IDLE: nominate the next winner so the resume picks it first.
      if (state_q == IDLE) begin
        owner_d     = sel;
        burst_cnt_d = '0;
      end
      state_d = STALL;
    end

    hold_vld_d = (hold_vld_q | capture) & ~drain;
    stall_d    = (state_d == STALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_vld_q   <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_wdata_q <= '0;
      grant_id_q   <= '0;
      stall_q      <= 1'b0;
      rdy_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_wdata_q <= fifo_wdata_d;
      grant_id_q   <= grant_id_d;
      stall_q      <= stall_d;
      rdy_en_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  assign bus.req_ready  = req_ready;
  assign bus.fifo_wr_en = fifo_wr_en_q;
  assign bus.fifo_wdata = fifo_wdata_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.stall      = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: accepted words are queued per requester
// and matched against every FIFO write; directed checks cover each scenario.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = 3;
  localparam int BMAX  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .BURST_MAX(BMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] sbq0[$];
  logic [WIDTH-1:0] sbq1[$];
  logic [IDW-1:0]   glog[$];
  logic [1:0]       auto_src = 2'b00;
  logic [1:0]       acc_prev = 2'b00;
  logic [WIDTH-1:0] dat0 = 32'h1000_0000;
  logic [WIDTH-1:0] dat1 = 32'h2000_0000;
  int               wr_cnt, b2b_cnt, stall_cnt, run, max_run, g0_cnt, g1_cnt;
  logic             prev_wr = 1'b0;
  logic [IDW-1:0]   last_gid = '0;
  logic [IDW-1:0]   exp_seq [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; b2b_cnt = 0; stall_cnt = 0; run = 0; max_run = 0;
    g0_cnt = 0; g1_cnt = 0;
    glog.delete();
  endtask

  task automatic observe();
    logic [WIDTH-1:0] exp_d;
    exp_d = '0;
    if (bus.stall) stall_cnt++;
    if (bus.fifo_wr_en) begin
      wr_cnt++;
      if (prev_wr) b2b_cnt++;
      if (run > 0 && bus.grant_id == last_gid) run++;
      else run = 1;
      if (run > max_run) max_run = run;
      last_gid = bus.grant_id;
      glog.push_back(bus.grant_id);
      if (bus.grant_id == IDW'(0)) begin
        g0_cnt++;
        chk("sb_avail0", 64'(sbq0.size() != 0), 64'(1));
        if (sbq0.size() != 0) exp_d = sbq0.pop_front();
      end else if (bus.grant_id == IDW'(1)) begin
        g1_cnt++;
        chk("sb_avail1", 64'(sbq1.size() != 0), 64'(1));
        if (sbq1.size() != 0) exp_d = sbq1.pop_front();
      end else begin
        chk("gid_range", 64'(bus.grant_id), 64'(1));
      end
      chk("sb_wdata", 64'(bus.fifo_wdata), 64'(exp_d));
    end
    prev_wr = bus.fifo_wr_en;
  endtask

  // Inputs are set between negedges; acceptance is recorded just before the active edge.
  task automatic step();
    logic [1:0] acc;
    acc = bus.req_valid & bus.req_ready;
    if (acc[0]) sbq0.push_back(bus.req_data[WIDTH-1:0]);
    if (acc[1]) sbq1.push_back(bus.req_data[2*WIDTH-1:WIDTH]);
    acc_prev = acc;
    @(posedge clk);
    @(negedge clk);
    observe();
    if (auto_src[0]) begin
      if (acc_prev[0]) dat0 = dat0 + 32'd1;
      bus.req_valid[0] = 1'b1;
      bus.req_data[WIDTH-1:0] = dat0;
    end
    if (auto_src[1]) begin
      if (acc_prev[1]) dat1 = dat1 + 32'd1;
      bus.req_valid[1] = 1'b1;
      bus.req_data[2*WIDTH-1:WIDTH] = dat1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arb_en      = 1'b1;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.fifo_status = ST_EMPTY;
    clear_stats();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'(0));
    chk("rst_wdata", 64'(bus.fifo_wdata), 64'(0));
    chk("rst_gid",   64'(bus.grant_id), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    rst_n = 1'b1;
    step();
    chk("rdy_after_rst", 64'(bus.req_ready), 64'(2'b11));

    // Single write
    bus.req_valid = 2'b01;
    bus.req_data[WIDTH-1:0] = 32'hDEAD_BEEF;
    step();
    chk("t1_rdy0_low", 64'(bus.req_ready[0]), 64'(0));
    chk("t1_no_wr_yet", 64'(bus.fifo_wr_en), 64'(0));
    bus.req_valid = 2'b00;
    step();
    chk("t1_wr_en", 64'(bus.fifo_wr_en), 64'(1));
    chk("t1_wdata", 64'(bus.fifo_wdata), 64'(32'hDEAD_BEEF));
    chk("t1_gid", 64'(bus.grant_id), 64'(0));
    chk("t1_rdy0_back", 64'(bus.req_ready[0]), 64'(1));
    step();
    chk("t1_wr_done", 64'(bus.fifo_wr_en), 64'(0));

    // arb_en low holds data without writing or stalling
    bus.arb_en = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_data[WIDTH-1:0] = 32'hA5A5_A5A5;
    step();
    bus.req_valid = 2'b00;
    clear_stats();
    repeat (3) step();
    chk("ae_no_wr", 64'(wr_cnt), 64'(0));
    chk("ae_no_stall", 64'(stall_cnt), 64'(0));
    chk("ae_held", 64'(bus.req_ready[0]), 64'(0));
    bus.arb_en = 1'b1;
    step();
    chk("ae_wr_en", 64'(bus.fifo_wr_en), 64'(1));
    chk("ae_gid", 64'(bus.grant_id), 64'(0));
    chk("ae_wdata", 64'(bus.fifo_wdata), 64'(32'hA5A5_A5A5));
    step();

    // Full FIFO blocks, then exactly one write once one slot is free
    bus.fifo_status = ST_FULL;
    bus.req_valid = 2'b10;
    bus.req_data[2*WIDTH-1:WIDTH] = 32'h1;
    step();
    bus.req_valid = 2'b00;
    clear_stats();
    chk("full_rdy1", 64'(bus.req_ready[1]), 64'(0));
    step();
    chk("full_stall", 64'(bus.stall), 64'(1));
    chk("full_no_wr", 64'(bus.fifo_wr_en), 64'(0));
    step();
    chk("full_stall2", 64'(bus.stall), 64'(1));
    bus.fifo_status = ST_0Q;
    step();
    chk("full_rel_wr", 64'(bus.fifo_wr_en), 64'(1));
    chk("full_rel_data", 64'(bus.fifo_wdata), 64'(32'h1));
    chk("full_rel_gid", 64'(bus.grant_id), 64'(1));
    chk("full_rel_stall", 64'(bus.stall), 64'(0));
    repeat (2) step();
    chk("full_one_write", 64'(wr_cnt), 64'(1));
    chk("full_stall_off", 64'(bus.stall), 64'(0));

    // Near-full throttle with both requesters saturated
    clear_stats();
    auto_src = 2'b11;
    bus.req_valid = 2'b11;
    bus.req_data = {dat1, dat0};
    repeat (10) step();
    chk("nf_10cyc_writes", 64'(wr_cnt), 64'(5));
    repeat (30) step();
    chk("nf_no_b2b", 64'(b2b_cnt), 64'(0));
    chk("nf_no_stall", 64'(stall_cnt), 64'(0));
    chk("nf_max_run", 64'(max_run), 64'(BMAX));
    chk("nf_glen", 64'(glog.size() >= 8), 64'(1));
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
      chk("nf_gseq", 64'(glog[i]), 64'(exp_seq[i]));
    end
    auto_src = 2'b00;
    bus.req_valid = 2'b00;
    bus.fifo_status = ST_EMPTY;
    repeat (6) step();
    chk("nf_drained", 64'(sbq0.size() + sbq1.size()), 64'(0));

    // Round robin at empty FIFO
    clear_stats();
    auto_src = 2'b11;
    bus.req_valid = 2'b11;
    bus.req_data = {dat1, dat0};
    repeat (20) step();
    chk("rr_max_run_le4", 64'(max_run <= BMAX), 64'(1));
    chk("rr_g0_served", 64'(g0_cnt > 0), 64'(1));
    chk("rr_g1_served", 64'(g1_cnt > 0), 64'(1));
    chk("rr_wr_cnt", 64'(wr_cnt), 64'(19));
    auto_src = 2'b00;
    bus.req_valid = 2'b00;
    repeat (6) step();
    chk("rr_drained", 64'(sbq0.size() + sbq1.size()), 64'(0));

    // Reset in the middle of a burst discards held data
    bus.fifo_status = ST_0Q;
    auto_src = 2'b11;
    bus.req_valid = 2'b11;
    bus.req_data = {dat1, dat0};
    repeat (7) step();
    chk("mb_both_held", 64'(bus.req_ready), 64'(0));
    rst_n = 1'b0;
    auto_src = 2'b00;
    bus.req_valid = 2'b00;
    sbq0.delete();
    sbq1.delete();
    #1;
    chk("mb_rst_wr", 64'(bus.fifo_wr_en), 64'(0));
    chk("mb_rst_rdy", 64'(bus.req_ready), 64'(0));
    chk("mb_rst_stall", 64'(bus.stall), 64'(0));
    step();
    chk("mb_rst_wr2", 64'(bus.fifo_wr_en), 64'(0));
    chk("mb_rst_rdy2", 64'(bus.req_ready), 64'(0));
    rst_n = 1'b1;
    clear_stats();
    step();
    chk("mb_rdy_release", 64'(bus.req_ready), 64'(2'b11));
    chk("mb_wr_release", 64'(bus.fifo_wr_en), 64'(0));
    repeat (3) step();
    chk("mb_no_stale", 64'(wr_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
